// File: rtl/ef_apb_requester.sv
// APB requester: turns a valid/ready command stream into single APB transfers, one response each.
// Latency: command accepted at edge 0 -> SETUP cycle 1 -> ACCESS cycle 2+ -> rsp_valid one cycle after PREADY.
// Backpressure: cmd_ready only in IDLE; response held stable until rsp_ready; wait states bounded by TIMEOUT.
//
// Ports:
//   PCLK, PRESETn                        clock, async active-low reset
//   cmd_valid/cmd_ready, cmd_write,
//   cmd_addr, cmd_wdata                  command stream (one transfer outstanding)
//   rsp_valid/rsp_ready, rsp_rdata,
//   rsp_err, rsp_timeout                 response stream
//   PADDR, PWRITE, PSEL, PENABLE, PWDATA,
//   PRDATA, PREADY, PSLVERR              APB requester side
module ef_apb_requester #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [31:0]           PADDR,
  output logic                  PWRITE,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic [31:0]           PWDATA,
  input  logic [31:0]           PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  // Counter wide enough to hold TIMEOUT; one bit when the timeout is disabled.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Count value seen during the TIMEOUT-th ACCESS cycle (first ACCESS cycle sees 0).
  localparam logic [CW-1:0] LAST_WAIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [1:0]    state_q,       state_d;
  logic [CW-1:0] wait_cnt_q,    wait_cnt_d;
  logic          cmd_ready_q,   cmd_ready_d;
  logic          psel_q,        psel_d;
  logic          penable_q,     penable_d;
  logic [31:0]   paddr_q,       paddr_d;
  logic          pwrite_q,      pwrite_d;
  logic [31:0]   pwdata_q,      pwdata_d;
  logic          rsp_valid_q,   rsp_valid_d;
  logic [31:0]   rsp_rdata_q,   rsp_rdata_d;
  logic          rsp_err_q,     rsp_err_d;
  logic          rsp_timeout_q, rsp_timeout_d;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          paddr_d   = 32'(cmd_addr);
          pwrite_d  = cmd_write;
          pwdata_d  = cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d  = 1'b1;
        wait_cnt_d = '0;
        state_d    = ACCESS;
      end
      ACCESS: begin
        // PREADY takes priority over a timeout firing in the same cycle.
        if (PREADY) begin
          rsp_rdata_d   = pwrite_q ? 32'd0 : PRDATA;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end else if ((TIMEOUT != 0) && (wait_cnt_q == LAST_WAIT)) begin
          rsp_rdata_d   = 32'd0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end else if (wait_cnt_q != '1) begin
          // Saturate rather than wrap (only reachable with the timeout disabled).
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered decode of IDLE so cmd_ready is 0 while in reset.
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      cmd_ready_q   <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      paddr_q       <= 32'd0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= 32'd0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 32'd0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PADDR       = paddr_q;
  assign PWRITE      = pwrite_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: doc/ef_apb_requester.md
Name: ef_apb_requester

Overview:
APB initiator (requester) that turns a simple valid/ready command stream into single APB transfers toward an APB completer such as the timer peripherals. It drives PSEL/PENABLE/PADDR/PWRITE/PWDATA and samples PRDATA/PREADY/PSLVERR. It returns one response per command on a valid/ready response port. A programmable wait-state timeout aborts transfers to a hung completer. It sits between firmware-model or DMA-style control logic and the peripheral APB bus.

Parameters:
ADDR_WIDTH, 32, width of cmd_addr; zero-extended onto 32-bit PADDR (must be <= 32)
TIMEOUT, 16, max ACCESS cycles allowed per transfer; 0 disables timeout

Ports:
PCLK  input  1  clock, all logic on rising edge
PRESETn  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  requester can accept a command
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  ADDR_WIDTH  target address
cmd_wdata  input  32  write data, ignored for reads
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_rdata  output  32  read data; 0 for writes and aborted transfers
rsp_err  output  1  PSLVERR seen, or timeout
rsp_timeout  output  1  transfer aborted by timeout
PADDR  output  32  APB address
PWRITE  output  1  APB direction
PSEL  output  1  APB select
PENABLE  output  1  APB enable
PWDATA  output  32  APB write data
PRDATA  input  32  APB read data
PREADY  input  1  APB ready
PSLVERR  input  1  APB error; tie 0 if the completer lacks it

Behaviour:
- All outputs are registered. Clock is PCLK. Reset is PRESETn, asynchronous, active-low.
- Reset values: state IDLE, every output 0 (cmd_ready reads 1 once reset is released, since it is decoded from IDLE).
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid & cmd_ready, latch write/addr/wdata, drive PADDR/PWRITE/PWDATA, set PSEL=1, PENABLE=0, go SETUP.
  - SETUP: lasts exactly 1 cycle. Set PENABLE=1, go ACCESS.
  - ACCESS: sample PREADY each cycle.
    - PREADY=1: capture PRDATA (reads only, else 0) into rsp_rdata, PSLVERR into rsp_err, rsp_timeout=0. Drop PSEL/PENABLE, set rsp_valid=1, go RESP.
    - Else, if TIMEOUT!=0 and this is the TIMEOUT-th ACCESS cycle: drop PSEL/PENABLE, rsp_rdata=0, rsp_err=1, rsp_timeout=1, rsp_valid=1, go RESP.
  - RESP: hold rsp_* stable while rsp_valid & !rsp_ready. On rsp_ready, clear rsp_valid and go IDLE.
- cmd_ready is 0 in SETUP, ACCESS and RESP. Only one transfer is outstanding at a time.
- PADDR/PWRITE/PWDATA stay stable from SETUP through the final ACCESS cycle. They hold their last values in IDLE/RESP and do not return to 0.
- Minimum latency: command accepted at edge 0, SETUP in cycle 1, ACCESS in cycle 2. With PREADY=1 in cycle 2, rsp_valid=1 in cycle 3.
- Back-to-back throughput with rsp_ready held high: 4 cycles per transfer.
- Wait-state counter: reset on entry to ACCESS, increments each ACCESS cycle with PREADY=0. No wrap; width is ceil(log2(TIMEOUT+1)).
- TIMEOUT=1 allows zero wait states.
- PREADY=1 in the same cycle the timeout would fire: PREADY wins, normal completion.
- PSLVERR is sampled only when PREADY=1 in ACCESS. rsp_rdata is still captured for an erroring read.
- cmd_valid while busy: ignored, not latched. Upstream must hold cmd_valid until it sees cmd_ready.
- PRESETn low mid-transfer: PSEL/PENABLE/rsp_valid drop to 0 immediately (asynchronously). The in-flight command and response are discarded. After release, the FSM is in IDLE.

Test Plan:
- Write 0x0000_0008 <- 0xA5A5_1234, PREADY=1 at first ACCESS -> exactly 1 SETUP cycle (PSEL=1, PENABLE=0) then 1 ACCESS cycle; PWDATA=0xA5A5_1234 and PWRITE=1 throughout; rsp_valid at cycle 3 with rsp_err=0, rsp_rdata=0.
- Read 0x0000_0010 with PREADY low for 3 cycles, PRDATA=0xDEAD_BEEF on the ready cycle -> 4 ACCESS cycles with PADDR stable; rsp_rdata=0xDEAD_BEEF, rsp_err=0.
- TIMEOUT=4, PREADY stuck 0 -> PSEL/PENABLE drop after the 4th ACCESS cycle; rsp_err=1, rsp_timeout=1, rsp_rdata=0. Repeat with PREADY=1 in the 4th cycle -> normal completion, rsp_timeout=0.
- Read with PSLVERR=1, PREADY=1, PRDATA=0x55 -> rsp_err=1, rsp_timeout=0, rsp_rdata=0x55.
- Hold rsp_ready=0 for 5 cycles, toggle cmd_valid meanwhile -> rsp_* stable, cmd_ready=0, no new PSEL. Then rsp_ready=1 -> IDLE next cycle. Also check back-to-back commands complete every 4 cycles.
- Assert PRESETn=0 during ACCESS -> PSEL, PENABLE, rsp_valid go 0 before the next PCLK edge; after release, cmd_ready=1 and no response is emitted for the aborted command.
